// File: rtl/multi_cycle_shift_unit.sv
// ---------------------------------------------------------------------------
// multi_cycle_shift_unit
//
// Sequential shift execution unit for the 8-bit ALU. It accepts an 8-bit
// shift distance and walks it down in steps of at most STEP_MAX positions.
// Each step goes through one 3-bit barrel shifter stage (LSL/LSR/ASR/ROR).
// Handshake: START is accepted in IDLE only. BUSY is high while in EXEC.
// DONE pulses for one cycle when RESULT/ZERO are updated.
//
// Optional build macro: SHIFT_EARLY_EXIT_EN
//   When defined, EXEC leaves for DONE as soon as the partial result is
//   saturated. Saturated means 8'h00 for LSL/LSR, or 8'h00/8'hFF for ASR.
//   RESULT values are the same in both builds; only the cycle count differs.
// ---------------------------------------------------------------------------
module multi_cycle_shift_unit #(
  parameter int STEP_MAX = 7
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [1:0] OPCODE,
  input  logic [7:0] DATA_IN,
  input  logic [7:0] SHIFT_AMOUNT,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RESULT,
  output logic       ZERO
);

  // Operation encodings as seen on OPCODE.
  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Per-cycle step limit. It is clamped to the 1..7 reach of a 3-bit shifter,
  // so an out-of-range parameter cannot wrap the step width.
  localparam int STEP_CLAMP = (STEP_MAX < 1) ? 1 : ((STEP_MAX > 7) ? 7 : STEP_MAX);
  localparam logic [7:0] STEP_LIMIT = 8'(STEP_CLAMP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // One barrel-shifter stage: shift value by k (0..7) positions according to op.
  function automatic logic [7:0] shift_step(
    input logic [7:0] value,
    input logic [1:0] op,
    input logic [2:0] k
  );
    logic [7:0] res;
    logic [3:0] back;
    res  = value;
    back = 4'd8 - {1'b0, k};
    case (op)
      OP_LSL: res = value << k;
      OP_LSR: res = value >> k;
      OP_ASR: res = $unsigned($signed(value) >>> k);
      OP_ROR: begin
        if (k == 3'd0) begin
          res = value;
        end else begin
          res = (value >> k) | (value << back);
        end
      end
      default: res = value;
    endcase
    return res;
  endfunction

`ifdef SHIFT_EARLY_EXIT_EN
  // Further shifting cannot change a saturated value, so the remaining
  // distance can be dropped. ROR never saturates.
  function automatic logic is_saturated(
    input logic [7:0] value,
    input logic [1:0] op
  );
    logic sat;
    sat = 1'b0;
    case (op)
      OP_LSL:  sat = (value == 8'h00);
      OP_LSR:  sat = (value == 8'h00);
      OP_ASR:  sat = (value == 8'h00) || (value == 8'hFF);
      OP_ROR:  sat = 1'b0;
      default: sat = 1'b0;
    endcase
    return sat;
  endfunction
`endif

  // Control and datapath state.
  state_t     state_r;
  state_t     state_s;
  logic [7:0] work_r;
  logic [7:0] rem_r;
  logic [1:0] op_r;

  // Output registers.
  logic       busy_r;
  logic       done_r;
  logic [7:0] result_r;
  logic       zero_r;

  // Per-cycle datapath values.
  logic [2:0] step_s;
  logic [7:0] shifted_s;
  logic [7:0] rem_left_s;
  logic       finish_s;

  // Step size, shifted value and the finish condition for the current EXEC cycle.
  always_comb begin
    step_s     = 3'd0;
    shifted_s  = work_r;
    rem_left_s = rem_r;
    finish_s   = 1'b0;
    if (rem_r < STEP_LIMIT) begin
      step_s = rem_r[2:0];
    end else begin
      step_s = STEP_LIMIT[2:0];
    end
    shifted_s  = shift_step(work_r, op_r, step_s);
    rem_left_s = rem_r - {5'd0, step_s};
`ifdef SHIFT_EARLY_EXIT_EN
    finish_s   = (rem_left_s == 8'd0) || is_saturated(shifted_s, op_r);
`else
    finish_s   = (rem_left_s == 8'd0);
`endif
  end

  // Next-state logic for the IDLE -> EXEC -> DONE -> IDLE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (finish_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register. Reset wins over everything, including an operation in flight.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the operands in IDLE and advance the working value/remaining distance in EXEC.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      work_r <= 8'h00;
      rem_r  <= 8'h00;
      op_r   <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            work_r <= DATA_IN;
            op_r   <= OPCODE;
            // Rotation is periodic in 8, so only the low three bits matter.
            if (OPCODE == OP_ROR) begin
              rem_r <= {5'd0, SHIFT_AMOUNT[2:0]};
            end else begin
              rem_r <= SHIFT_AMOUNT;
            end
          end else begin
            work_r <= work_r;
            op_r   <= op_r;
            rem_r  <= rem_r;
          end
        end
        ST_EXEC: begin
          work_r <= shifted_s;
          rem_r  <= rem_left_s;
        end
        default: begin
          work_r <= work_r;
          rem_r  <= rem_r;
          op_r   <= op_r;
        end
      endcase
    end
  end

  // Registered handshake flags follow the next state. RESULT/ZERO load on the edge into DONE.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 8'h00;
      zero_r   <= 1'b1;
    end else begin
      busy_r <= (state_s == ST_EXEC);
      done_r <= (state_s == ST_DONE);
      if ((state_r == ST_EXEC) && finish_s) begin
        result_r <= shifted_s;
        zero_r   <= (shifted_s == 8'h00);
      end else begin
        result_r <= result_r;
        zero_r   <= zero_r;
      end
    end
  end

  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign RESULT = result_r;
  assign ZERO   = zero_r;

endmodule

// File: tb/tb_multi_cycle_shift_unit.sv
// ---------------------------------------------------------------------------
// Testbench for multi_cycle_shift_unit.
// The driver issues operations and pushes the expected response into a queue.
// The monitor pops from that queue on every DONE pulse and compares. Random
// operations are checked against an arithmetic reference model.
// The build macro SHIFT_EARLY_EXIT_EN selects the expected cycle counts.
// ---------------------------------------------------------------------------
module tb_multi_cycle_shift_unit;

  localparam int TB_STEP = 7;

  logic       CLK;
  logic       RESET_N;
  logic       START;
  logic [1:0] OPCODE;
  logic [7:0] DATA_IN;
  logic [7:0] SHIFT_AMOUNT;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT;
  logic       ZERO;

  multi_cycle_shift_unit #(.STEP_MAX(TB_STEP)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .START        (START),
    .OPCODE       (OPCODE),
    .DATA_IN      (DATA_IN),
    .SHIFT_AMOUNT (SHIFT_AMOUNT),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .RESULT       (RESULT),
    .ZERO         (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] result;
    logic       zero;
    int         cycles;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad = 0;
  int timeouts_issued = 0;
  int timeouts_seen = 0;
  logic rst_at_edge = 1'b0;

  // Reference result: the full shift done in one go with plain arithmetic.
  function automatic logic [7:0] ref_result(input int op, input int d, input int amt);
    int r;
    int s;
    int a;
    r = 0;
    case (op)
      0: r = (amt >= 8) ? 0 : ((d << amt) & 255);
      1: r = (amt >= 8) ? 0 : (d >> amt);
      2: begin
        s = (d >= 128) ? d - 256 : d;
        if (amt >= 8) r = (d >= 128) ? 255 : 0;
        else          r = (s >>> amt) & 255;
      end
      default: begin
        a = amt % 8;
        r = ((d >> a) | (d << (8 - a))) & 255;
      end
    endcase
    return r[7:0];
  endfunction

  // Reference EXEC cycle count, from the latency rule (plus early exit when built in).
  function automatic int ref_cycles(input int op, input int d, input int amt);
    int rem;
    int c;
    int v;
    rem = (op == 3) ? amt % 8 : amt;
`ifdef SHIFT_EARLY_EXIT_EN
    if (op != 3) begin
      for (int i = 1; i <= 64; i++) begin
        c = (i * TB_STEP < rem) ? i * TB_STEP : rem;
        v = int'(ref_result(op, d, c));
        if (c == rem || v == 0 || (op == 2 && v == 255)) return i;
      end
    end
`endif
    if (rem == 0) return 1;
    return (rem + TB_STEP - 1) / TB_STEP;
  endfunction

  function automatic exp_t mk_exp(input logic [7:0] r, input int cyc);
    exp_t e;
    e.result = r;
    e.zero   = (r == 8'h00);
    e.cycles = cyc;
    return e;
  endfunction

  // Record whether reset was applied at each rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      rst_at_edge = RESET_N;
    end
  end

  // Monitor: check reset outputs, RESULT hold, DONE width, and scoreboard on DONE.
  initial begin
    int exec_cnt;
    logic [7:0] last_result;
    logic prev_done;
    exp_t e;
    exec_cnt = 0;
    last_result = 8'h00;
    prev_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (timeouts_issued != timeouts_seen) begin
        total++; bad++;
        $display("FAIL timeout: got no DONE within budget (pending=%0d) expected DONE", timeouts_issued - timeouts_seen);
        timeouts_seen = timeouts_issued;
      end
      if (!rst_at_edge) begin
        total++;
        if ({BUSY, DONE, RESULT, ZERO} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
          bad++;
          $display("FAIL reset_state: busy=%b done=%b result=%h zero=%b expected 0 0 00 1", BUSY, DONE, RESULT, ZERO);
        end
        exec_cnt = 0;
        last_result = 8'h00;
        prev_done = 1'b0;
      end else begin
        if (BUSY === 1'b1) exec_cnt++;
        if (DONE === 1'b1) begin
          total++;
          if (prev_done) begin
            bad++;
            $display("FAIL done_width: DONE high on two consecutive cycles, expected one-cycle pulse");
          end
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: result=%h, expected no DONE", RESULT);
          end else begin
            e = sb_q.pop_front();
            total++;
            if (RESULT !== e.result) begin
              bad++;
              $display("FAIL result: got %h expected %h", RESULT, e.result);
            end
            total++;
            if (ZERO !== e.zero) begin
              bad++;
              $display("FAIL zero: got %b expected %b", ZERO, e.zero);
            end
            total++;
            if (exec_cnt != e.cycles) begin
              bad++;
              $display("FAIL exec_cycles: got %0d expected %0d", exec_cnt, e.cycles);
            end
          end
          exec_cnt = 0;
          last_result = RESULT;
        end else begin
          total++;
          if (RESULT !== last_result) begin
            bad++;
            $display("FAIL result_hold: got %h expected %h", RESULT, last_result);
          end
        end
        prev_done = (DONE === 1'b1);
      end
    end
  end

  // Wait (bounded) until the unit is back in IDLE.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((BUSY || DONE) && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  // Wait (bounded) until the scoreboard holds at most 'level' entries.
  task automatic drain_to(input int level);
    int n;
    n = 0;
    while (sb_q.size() > level && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    if (sb_q.size() > level) begin
      timeouts_issued++;
      sb_q.delete();
    end
  endtask

  // Issue one operation with a given expectation, then wait for it to finish.
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [7:0] amt, input exp_t e);
    wait_idle();
    OPCODE = op;
    DATA_IN = d;
    SHIFT_AMOUNT = amt;
    START = 1'b1;
    sb_q.push_back(e);
    @(posedge CLK); #1;
    START = 1'b0;
    drain_to(0);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: reset, directed cases, held START with a mid-EXEC reset, then random operations.
  initial begin
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] amt;
    int n;
    RESET_N = 1'b0;
    START = 1'b0;
    OPCODE = 2'b00;
    DATA_IN = 8'h00;
    SHIFT_AMOUNT = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    issue(2'b00, 8'h81, 8'd1, mk_exp(8'h02, 1));
`ifdef SHIFT_EARLY_EXIT_EN
    issue(2'b01, 8'hF0, 8'd20, mk_exp(8'h00, 2));
    issue(2'b10, 8'h80, 8'd200, mk_exp(8'hFF, 1));
`else
    issue(2'b01, 8'hF0, 8'd20, mk_exp(8'h00, 3));
    issue(2'b10, 8'h80, 8'd200, mk_exp(8'hFF, 29));
`endif
    issue(2'b11, 8'hA5, 8'd11, mk_exp(8'hB4, 1));
    issue(2'b11, 8'hA5, 8'd8, mk_exp(8'hA5, 1));
    issue(2'b00, 8'h5A, 8'd0, mk_exp(8'h5A, 1));
    issue(2'b10, 8'h40, 8'd255, mk_exp(8'h00, ref_cycles(2, 8'h40, 255)));

    // START held high: the second operation may begin only after returning to IDLE.
    wait_idle();
    OPCODE = 2'b01;
    DATA_IN = 8'hFF;
    SHIFT_AMOUNT = 8'd30;
    START = 1'b1;
`ifdef SHIFT_EARLY_EXIT_EN
    sb_q.push_back(mk_exp(8'h00, 2));
    sb_q.push_back(mk_exp(8'h00, 2));
`else
    sb_q.push_back(mk_exp(8'h00, 5));
    sb_q.push_back(mk_exp(8'h00, 5));
`endif
    drain_to(1);
    n = 0;
    while (!BUSY && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    @(posedge CLK); #1;
    // Abort the second operation mid-EXEC. It must not produce DONE.
    RESET_N = 1'b0;
    START = 1'b0;
    sb_q.delete();
    repeat (2) begin
      @(posedge CLK); #1;
    end
    RESET_N = 1'b1;
    repeat (8) begin
      @(posedge CLK); #1;
    end

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) amt = 8'($urandom_range(0, 15));
      else amt = 8'($urandom_range(0, 255));
      issue(op, d, amt, mk_exp(ref_result(int'(op), int'(d), int'(amt)),
                               ref_cycles(int'(op), int'(d), int'(amt))));
    end

    repeat (3) begin
      @(posedge CLK); #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
